// File: rtl/fsmc_regfile_if.sv
// ---------------------------------------------------------------------------
// fsmc_regfile_if : FSMC control/address bundle between MCU pins and the
// register file.
//   cs0_n : chip select, active-low, asynchronous to the fabric clock
//   rd_n  : read strobe (NOE), active-low
//   wr_n  : write strobe (NWE), active-low
//   ab    : register address
// The bidirectional data bus stays a plain inout on the register file so the
// tristate driver lives in one module next to its enable.
// ---------------------------------------------------------------------------
interface fsmc_regfile_if #(
    parameter int AW = 3
);
    logic          cs0_n;
    logic          rd_n;
    logic          wr_n;
    logic [AW-1:0] ab;

    modport master (output cs0_n, output rd_n, output wr_n, output ab);
    modport slave  (input  cs0_n, input  rd_n, input  wr_n, input  ab);
endinterface

// File: rtl/fsmc_regfile.sv
// ---------------------------------------------------------------------------
// fsmc_regfile : STM32 FSMC slave register file, 2**AW registers of DW bits.
// All state lives in the i_fpga_clk2 domain; bus control, address and data
// are double-flopped before the write detector uses them.
//
// Ports
//   i_fpga_clk2 : system clock
//   i_rst       : asynchronous active-high reset
//   bus         : FSMC chip select / read / write strobes and address (slave)
//   io_db       : FSMC data bus, driven only during a valid read
//   o_reg_out   : flattened register contents, register i at [i*DW +: DW]
//   o_wr_stb    : one-cycle strobe per register, bit i when register i written
//
// Build option
//   FSMC_ID_REG_EN : when defined, address N-1 is a read-only ID register
//                    returning ID_VAL; writes to it only pulse its strobe.
// ---------------------------------------------------------------------------
module fsmc_regfile #(
    parameter int            DW        = 16,
    parameter int            AW        = 3,
    parameter logic [DW-1:0] RESET_VAL = '0,
    parameter logic [DW-1:0] ID_VAL    = 16'hB11C
) (
    input  logic                   i_fpga_clk2,
    input  logic                   i_rst,
    fsmc_regfile_if.slave          bus,
    inout  wire  [DW-1:0]          io_db,
    output logic [(2**AW)*DW-1:0]  o_reg_out,
    output logic [2**AW-1:0]       o_wr_stb
);
    localparam int N = 2 ** AW;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COMMIT, S_WAIT} state_t;

    logic [1:0]    r_cs_sync;
    logic [1:0]    r_wr_sync;
    logic [AW-1:0] r_ab_p0, r_ab_p1;
    logic [DW-1:0] r_db_p0, r_db_p1;
    logic          w_cs_s, w_wr_s;

    state_t        r_state, w_state_nxt;
    logic          w_do_write;
    logic          w_reg_we;
    logic [N-1:0]  w_stb_nxt;
    logic [N-1:0]  r_wr_stb;

    logic [DW-1:0] r_regs [N];
    logic [DW-1:0] w_view [N];
    logic [DW-1:0] r_rd_q;
    logic          w_db_oe;

    // Synchroniser stage. RD is only used combinationally by the bus driver,
    // so it needs no synchroniser.
    always_ff @(posedge i_fpga_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_cs_sync <= 2'b11;
            r_wr_sync <= 2'b11;
            r_ab_p0   <= '0;
            r_ab_p1   <= '0;
            r_db_p0   <= '0;
            r_db_p1   <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[0], bus.cs0_n};
            r_wr_sync <= {r_wr_sync[0], bus.wr_n};
            r_ab_p0   <= bus.ab;
            r_ab_p1   <= r_ab_p0;
            r_db_p0   <= io_db;
            r_db_p1   <= r_db_p0;
        end
    end

    assign w_cs_s = r_cs_sync[1];
    assign w_wr_s = r_wr_sync[1];

    // Write detector: state register.
    always_ff @(posedge i_fpga_clk2 or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Write detector: next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_cs_s && !w_wr_s) w_state_nxt = S_ARMED;
            S_ARMED:  w_state_nxt = (!w_cs_s && !w_wr_s) ? S_COMMIT : S_IDLE;
            S_COMMIT: w_state_nxt = S_WAIT;
            S_WAIT:   if (w_wr_s || w_cs_s) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Write detector: outputs. The write is issued on the edge that enters
    // COMMIT, so the register and its strobe change together on that edge
    // and the strobe is high for exactly the COMMIT cycle.
    always_comb begin
        w_do_write = (r_state == S_ARMED) && !w_cs_s && !w_wr_s;
        w_stb_nxt  = '0;
        if (w_do_write) w_stb_nxt[r_ab_p1] = 1'b1;
`ifdef FSMC_ID_REG_EN
        w_reg_we   = w_do_write && (r_ab_p1 != AW'(N - 1));
`else
        w_reg_we   = w_do_write;
`endif
    end

    // Register file and strobe stage.
    always_ff @(posedge i_fpga_clk2 or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) r_regs[i] <= RESET_VAL;
            r_wr_stb <= '0;
        end else begin
            if (w_reg_we) r_regs[r_ab_p1] <= r_db_p1;
            r_wr_stb <= w_stb_nxt;
        end
    end

    // Visible register contents (ID register substituted when enabled).
    always_comb begin
        for (int i = 0; i < N; i++) w_view[i] = r_regs[i];
`ifdef FSMC_ID_REG_EN
        w_view[N-1] = ID_VAL;
`endif
    end

    always_comb begin
        o_reg_out = '0;
        for (int i = 0; i < N; i++) o_reg_out[i*DW +: DW] = w_view[i];
    end

    assign o_wr_stb = r_wr_stb;

    // Read mux stage.
    always_ff @(posedge i_fpga_clk2 or posedge i_rst) begin
        if (i_rst) r_rd_q <= '0;
        else       r_rd_q <= w_view[r_ab_p1];
    end

    // Raw pins gate the driver so the bus is released as soon as the MCU lets
    // go of RD/CS0; WR low suppresses drive to avoid contention on writes.
    assign w_db_oe = !bus.cs0_n && !bus.rd_n && bus.wr_n && !i_rst;
    assign io_db   = w_db_oe ? r_rd_q : 'z;

endmodule

// File: tb/tb_fsmc_regfile.sv
// ---------------------------------------------------------------------------
// tb_fsmc_regfile : directed bench for fsmc_regfile (DW=16, AW=3).
// ---------------------------------------------------------------------------
module tb_fsmc_regfile;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 8;
`ifdef FSMC_ID_REG_EN
    localparam logic [DW-1:0] R7_RST = 16'hB11C;
`else
    localparam logic [DW-1:0] R7_RST = 16'h0000;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            tb_oe;
    logic [DW-1:0]   tb_db;
    wire  [DW-1:0]   db;
    logic [N*DW-1:0] reg_out;
    logic [N-1:0]    wr_stb;

    int              total = 0;
    int              bad   = 0;
    int              stb_cnt = 0;
    logic [N-1:0]    stb_or = '0;
    logic [DW-1:0]   m [N];
    logic [N*DW-1:0] exp_out;

    fsmc_regfile_if #(.AW(AW)) bus ();

    fsmc_regfile #(.DW(DW), .AW(AW)) dut (
        .i_fpga_clk2 (clk),
        .i_rst       (rst),
        .bus         (bus.slave),
        .io_db       (db),
        .o_reg_out   (reg_out),
        .o_wr_stb    (wr_stb)
    );

    assign db = tb_oe ? tb_db : 'z;

    always #5 clk = ~clk;

    // Strobe pulses sampled mid-cycle, so each one-cycle pulse counts once.
    always @(negedge clk) begin
        if (wr_stb != '0) begin
            stb_cnt = stb_cnt + 1;
            stb_or  = stb_or | wr_stb;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp();
        for (int i = 0; i < N; i++) exp_out[i*DW +: DW] = m[i];
    endtask

    task automatic clr_stb();
        @(negedge clk);
        stb_cnt = 0;
        stb_or  = '0;
    endtask

    // CS0 low with address/data set up 4 cycles before WR falls, WR low for
    // nlow cycles, then everything released for long enough to reach IDLE.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int nlow);
        @(negedge clk);
        bus.ab = a; tb_db = d; tb_oe = 1'b1; bus.cs0_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.wr_n = 1'b0;
        repeat (nlow) @(negedge clk);
        bus.wr_n = 1'b1; bus.cs0_n = 1'b1;
        repeat (4) @(negedge clk);
        tb_oe = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cs0_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.ab = '0;
        tb_oe = 1'b0; tb_db = '0;
        for (int i = 0; i < N; i++) m[i] = 16'h0000;
        m[7] = R7_RST;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        build_exp();
        chk("rst_regout", reg_out, exp_out);
        chk("rst_stb", wr_stb, 8'h00);
        chk("rst_oe", dut.w_db_oe, 1'b0);

        // Single write with exact commit edge
        @(negedge clk);
        bus.ab = 3'd2; tb_db = 16'hE000; tb_oe = 1'b1; bus.cs0_n = 1'b0;
        repeat (4) @(negedge clk);
        stb_cnt = 0; stb_or = '0;
        bus.wr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wr_edge3_reg2", reg_out[47:32], 16'h0000);
        chk("wr_edge3_stb", wr_stb, 8'h00);
        @(posedge clk); #1;
        chk("wr_edge4_reg2", reg_out[47:32], 16'hE000);
        chk("wr_edge4_stb", wr_stb, 8'h04);
        @(posedge clk); #1;
        chk("wr_edge5_stb", wr_stb, 8'h00);
        @(negedge clk);
        bus.wr_n = 1'b1; bus.cs0_n = 1'b1;
        repeat (4) @(negedge clk);
        tb_oe = 1'b0;
        m[2] = 16'hE000;
        build_exp();
        chk("wr_regout", reg_out, exp_out);
        chk("wr_stb_cnt", stb_cnt, 1);

        // Long pulse: one write, one strobe
        clr_stb();
        do_write(3'd3, 16'hA5A5, 40);
        m[3] = 16'hA5A5;
        build_exp();
        chk("long_regout", reg_out, exp_out);
        chk("long_stb_cnt", stb_cnt, 1);
        chk("long_stb_bits", stb_or, 8'h08);

        // Short pulse: nothing happens
        clr_stb();
        do_write(3'd4, 16'h5555, 1);
        chk("short_regout", reg_out, exp_out);
        chk("short_stb_cnt", stb_cnt, 0);

        // Readback with latency from address change
        do_write(3'd5, 16'h1234, 6);
        m[5] = 16'h1234;
        @(negedge clk);
        bus.ab = 3'd0;
        repeat (4) @(negedge clk);
        bus.cs0_n = 1'b0; bus.rd_n = 1'b0; bus.ab = 3'd5;
        #1;
        chk("rd_oe_on", dut.w_db_oe, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rd_edge2_db", db, 16'h0000);
        @(posedge clk); #1;
        chk("rd_edge3_db", db, 16'h1234);
        @(negedge clk);
        bus.rd_n = 1'b1; #1;
        chk("rd_oe_rd_high", dut.w_db_oe, 1'b0);
        @(negedge clk);
        bus.rd_n = 1'b0; bus.wr_n = 1'b0; #1;
        chk("rd_oe_wr_low", dut.w_db_oe, 1'b0);
        @(negedge clk);
        bus.wr_n = 1'b1; #1;
        chk("rd_oe_again", dut.w_db_oe, 1'b1);
        @(negedge clk);
        bus.cs0_n = 1'b1; #1;
        chk("rd_oe_cs_high", dut.w_db_oe, 1'b0);
        @(negedge clk);
        bus.rd_n = 1'b1;
        repeat (4) @(negedge clk);

        // Aborted write: CS0 rises one clock after WR falls
        clr_stb();
        bus.ab = 3'd6; tb_db = 16'h7777; tb_oe = 1'b1; bus.cs0_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.wr_n = 1'b0;
        @(negedge clk);
        bus.cs0_n = 1'b1;
        @(negedge clk);
        bus.wr_n = 1'b1;
        repeat (5) @(negedge clk);
        tb_oe = 1'b0;
        build_exp();
        chk("abort_regout", reg_out, exp_out);
        chk("abort_stb_cnt", stb_cnt, 0);

        // Address N-1
        clr_stb();
        do_write(3'd7, 16'hFFFF, 6);
`ifndef FSMC_ID_REG_EN
        m[7] = 16'hFFFF;
`endif
        build_exp();
        chk("r7_regout", reg_out, exp_out);
        chk("r7_stb_cnt", stb_cnt, 1);
        chk("r7_stb_bits", stb_or, 8'h80);
        @(negedge clk);
        bus.cs0_n = 1'b0; bus.rd_n = 1'b0;
        repeat (4) @(negedge clk);
`ifdef FSMC_ID_REG_EN
        chk("r7_read", db, 16'hB11C);
`else
        chk("r7_read", db, 16'hFFFF);
`endif

        // Reset asserted mid-read
        bus.ab = 3'd5;
        repeat (4) @(negedge clk);
        chk("mid_read_db", db, 16'h1234);
        rst = 1'b1; #1;
        chk("rst_oe_immediate", dut.w_db_oe, 1'b0);
        for (int i = 0; i < N; i++) m[i] = 16'h0000;
        m[7] = R7_RST;
        build_exp();
        chk("rst_async_regout", reg_out, exp_out);
        @(negedge clk);
        bus.cs0_n = 1'b1; bus.rd_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_regout", reg_out, exp_out);
        chk("post_rst_stb", wr_stb, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fsmc_regfile.md
# fsmc_regfile

Parametrised STM32 FSMC slave register file: 2^AW registers of DW bits, written and read by the MCU over the asynchronous FSMC bus, with all register state kept in the FPGA_CLK2 domain. Bus control is synchronised before use, and each write produces a one-cycle strobe toward fabric logic such as LED/PWM drivers. It sits between the FSMC pins and the application logic, and replaces single-register, WR-edge-clocked bus decoding.

## Interface
- DW, 16, data bus and register width
- AW, 3, address bits; register count N = 2^AW
- RESET_VAL, 0, reset value of every read/write register
- ID_VAL, 16'hB11C, constant returned by the ID register (see Configuration)

- FPGA_CLK2  in  1  system clock; every flop uses it
- RST  in  1  reset, asynchronous, active-high
- CS0  in  1  FSMC chip select, active-low, asynchronous
- RD  in  1  FSMC read strobe (NOE), active-low, asynchronous
- WR  in  1  FSMC write strobe (NWE), active-low, asynchronous
- AB  in  AW  FSMC address, asynchronous
- DB  inout  DW  FSMC data bus, tristated when this block is not driving it
- REG_OUT  out  N*DW  flattened register contents; register i occupies [i*DW +: DW]
- WR_STB  out  N  bit i pulses high for one cycle when register i is written

## Operation
- Synchroniser:
  - CS0, RD and WR each pass through 2 flops, giving cs_s, rd_s and wr_s. These flops reset to 1 (idle).
  - AB and DB each pass through 2 flops, giving ab_s and db_s. These flops reset to 0.
- Write detector state machine, clocked on FPGA_CLK2:
  - IDLE -> ARMED when cs_s==0 && wr_s==0.
  - ARMED -> COMMIT when cs_s==0 && wr_s==0 still hold on the next cycle.
  - ARMED -> IDLE otherwise.
  - COMMIT -> WAIT unconditionally.
  - WAIT -> IDLE when wr_s==1 || cs_s==1.
  - In COMMIT: reg[ab_s] <= db_s, and WR_STB[ab_s] <= 1. WR_STB is 0 in every other state.
  - Result: exactly one write per WR low pulse, however long the pulse is.
- A WR pulse shorter than 2 synchronised cycles, or CS0 deasserting before COMMIT, performs no write and no strobe.
- Read path:
  - rd_q <= reg[ab_s] on every cycle. rd_q resets to 0.
  - DB = rd_q when (CS0==0 && RD==0 && WR==1 && RST==0). These are raw pins, combinational enable. Otherwise DB is hi-Z.
- Simultaneous RD and WR low: no drive on DB; the write path operates normally.
- Width rules:
  - AB indexes all N registers; there are no unmapped addresses.
  - Data is written full-width, with no byte lanes.
- Reset, at any time including mid-transaction:
  - All registers = RESET_VAL, WR_STB = 0, rd_q = 0, DB hi-Z, FSM = IDLE.
  - A write interrupted by reset is lost.

## Timing
- Write commit: COMMIT is the 4th FPGA_CLK2 rising edge after raw WR/CS0 go low (2 sync edges + ARMED + COMMIT). REG_OUT and WR_STB change on that same edge.
- Write bus requirements on the FSMC side:
  - DATAST ≥ 5 FPGA_CLK2 periods.
  - AB and DB stable for ≥ 4 periods before WR falls + DATAST.
- Read latency: rd_q reflects a new AB 3 edges after AB changes (2 sync + 1 mux register). FSMC ADDSET + DATAST ≥ 4 periods before the MCU samples.
- Write-then-read of the same register: the new value appears on rd_q 1 edge after COMMIT.
- Minimum back-to-back write spacing: WR high for ≥ 3 periods so that WAIT returns to IDLE.

## Configuration
- FSMC_ID_REG_EN
  - Defined:
    - Address N-1 is read-only and reads ID_VAL.
    - A write to N-1 leaves no state change, but WR_STB[N-1] still pulses so software handshakes keep working.
    - REG_OUT slice N-1 = ID_VAL.
  - Undefined: address N-1 is an ordinary read/write register.

## Test plan
- Reset: assert RST mid-read with RD/CS0 low -> DB hi-Z immediately. After release, every REG_OUT slice = RESET_VAL and WR_STB = 0.
- Write: AB=2, DB=16'hE000, WR low for 6 clocks -> REG_OUT[47:32]=16'hE000 on the 4th edge after WR falls. WR_STB=3'b...100 (bit 2 only) for exactly 1 cycle. No other register changes.
- Long/short pulses:
  - WR low for 40 clocks -> exactly one WR_STB pulse.
  - WR low for 1 clock -> no write, no strobe.
- Readback: write 16'h1234 to address 5, then RD low at AB=5 -> DB=16'h1234 from the 3rd edge after AB is stable. DB hi-Z once RD or CS0 rises.
- Aborted write: CS0 rises 1 clock after WR falls -> register unchanged, no strobe.
- With FSMC_ID_REG_EN: read address 7 -> 16'hB11C. Write 16'hFFFF to address 7 -> readback is still 16'hB11C and WR_STB[7] pulses once.
